// File: rtl/layer1_sequencer_if.sv
// Control bundle between the Layer 1 sequencer, its input queue, weight path and Layer 2.
// master = sequencer side, slave = queue/datapath/Layer 2 side.
interface layer1_sequencer_if #(
    parameter int ADDR_WIDTH  = 10,
    parameter int COUNT_WIDTH = 10
);
    logic                   queueFinished;
    logic                   queueEmpty;
    logic [ADDR_WIDTH-1:0]  queueOut;
    logic                   cfgWriteActive;
    logic [ADDR_WIDTH-1:0]  cfgAddr;
    logic                   outputsRecieved;
    logic                   dequeue;
    logic [ADDR_WIDTH-1:0]  storeAddr;
    logic                   bufAWrite;
    logic                   bufBWrite;
    logic                   accClear;
    logic                   accEnable;
    logic                   reluTrigger;
    logic                   inputsRecieved;
    logic                   outputsReady;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] inputCount;
    logic                   overflow;
    logic                   timeout;

    modport master (
        input  queueFinished, queueEmpty, queueOut, cfgWriteActive, cfgAddr, outputsRecieved,
        output dequeue, storeAddr, bufAWrite, bufBWrite, accClear, accEnable, reluTrigger,
               inputsRecieved, outputsReady, busy, inputCount, overflow, timeout
    );

    modport slave (
        output queueFinished, queueEmpty, queueOut, cfgWriteActive, cfgAddr, outputsRecieved,
        input  dequeue, storeAddr, bufAWrite, bufBWrite, accClear, accEnable, reluTrigger,
               inputsRecieved, outputsReady, busy, inputCount, overflow, timeout
    );
endinterface

// File: rtl/layer1_sequencer.sv
// Frame sequencer for the Layer 1 datapath (queue -> weight buffers -> pStore -> RELU -> Layer 2).
// Optional output-handshake watchdog: define LAYER1_SEQ_TIMEOUT_EN.
module layer1_sequencer #(
    parameter int ADDR_WIDTH     = 10,
    parameter int MAX_INPUTS     = 784,
    parameter int COUNT_WIDTH    = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                clk,
    input logic                reset,
    layer1_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RELU, OUTPUT} state_t;

    localparam logic [COUNT_WIDTH-1:0] CountMax = COUNT_WIDTH'(MAX_INPUTS);

    state_t                 state, stateNext;
    logic [ADDR_WIDTH-1:0]  fetchAddr;
    logic [COUNT_WIDTH-1:0] countReg;
    logic                   sel, pending, frameDone, readyReg, overflowReg;
    logic                   pop, frameEnd, giveUp;

    assign frameEnd = (state == OUTPUT) && (bus.outputsRecieved || giveUp);

`ifdef LAYER1_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] waitCnt;
    logic          timeoutReg;

    assign giveUp = (state == OUTPUT) && !bus.outputsRecieved &&
                    (waitCnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt    <= '0;
            timeoutReg <= 1'b0;
        end else begin
            waitCnt <= (state == OUTPUT && !frameEnd) ? waitCnt + 1'b1 : '0;
            if (giveUp) timeoutReg <= 1'b1;
        end
    end

    assign bus.timeout = timeoutReg;
`else
    assign giveUp      = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext          = state;
        pop                = 1'b0;
        bus.inputsRecieved = 1'b0;
        case (state)
            IDLE:   if (bus.queueFinished && !frameDone && !bus.cfgWriteActive) stateNext = CLEAR;
            CLEAR:  stateNext = STREAM;
            STREAM: begin
                // An empty queue ends the frame even while a config write holds the address.
                if (bus.queueEmpty) begin
                    stateNext          = DRAIN;
                    bus.inputsRecieved = 1'b1;
                end else if (!bus.cfgWriteActive) begin
                    pop = 1'b1;
                end
            end
            DRAIN:  stateNext = RELU;
            RELU:   stateNext = OUTPUT;
            OUTPUT: if (frameEnd) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetchAddr   <= '0;
            countReg    <= '0;
            sel         <= 1'b0;
            pending     <= 1'b0;
            frameDone   <= 1'b0;
            readyReg    <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            pending <= pop;
            if (state == CLEAR) begin
                countReg    <= '0;
                overflowReg <= 1'b0;
                sel         <= 1'b1;  // first entry of a frame lands in buffer A
            end
            if (pop) begin
                fetchAddr <= bus.queueOut;
                sel       <= ~sel;
                if (countReg == CountMax) overflowReg <= 1'b1;
                else                      countReg    <= countReg + 1'b1;
            end
            if (state == RELU) readyReg <= 1'b1;
            if (frameEnd) begin
                readyReg  <= 1'b0;
                frameDone <= 1'b1;
            end
            if (state == IDLE && !bus.queueFinished) frameDone <= 1'b0;
        end
    end

    // Config writes own the weight-storage address whenever they are active.
    assign bus.storeAddr    = bus.cfgWriteActive ? bus.cfgAddr : fetchAddr;
    assign bus.dequeue      = pop;
    assign bus.bufAWrite    = pop & sel;
    assign bus.bufBWrite    = pop & ~sel;
    assign bus.accClear     = (state == CLEAR);
    assign bus.accEnable    = pending && (state == STREAM || state == DRAIN);
    assign bus.reluTrigger  = (state == RELU);
    assign bus.outputsReady = readyReg;
    assign bus.busy         = (state != IDLE);
    assign bus.inputCount   = countReg;
    assign bus.overflow     = overflowReg;
endmodule
